// File: rtl/spi_xip_pkg.sv
// Shared definitions for the SPI XIP APB bridge.
//  - spi_top register offsets and CTRL bit positions
//  - XIP CTRL words
//  - bridge FSM state encoding
//  - Wishbone single-access request struct and builders
//  - byte-order helper
package spi_xip_pkg;

    localparam logic [4:0] REG_RX0  = 5'h00;
    localparam logic [4:0] REG_TX1  = 5'h04;
    localparam logic [4:0] REG_CTRL = 5'h10;
    localparam logic [4:0] REG_DIV  = 5'h14;
    localparam logic [4:0] REG_SS   = 5'h18;

    localparam int CTRL_GO_BSY = 8;
    localparam int CTRL_TX_NEG = 10;
    localparam int CTRL_ASS    = 13;

    localparam logic [6:0] CHAR_LEN_XIP = 7'd64;

    // ASS | TX_NEG | CHAR_LEN=64 -> 0x2440; with GO_BSY -> 0x2540
    localparam logic [31:0] CTRL_XIP    = (32'd1 << CTRL_ASS) | (32'd1 << CTRL_TX_NEG)
                                        | {25'd0, CHAR_LEN_XIP};
    localparam logic [31:0] CTRL_XIP_GO = CTRL_XIP | (32'd1 << CTRL_GO_BSY);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PASS,
        ST_WR_TX1,
        ST_WR_DIV,
        ST_WR_SS,
        ST_WR_CTRL,
        ST_WR_GO,
        ST_POLL,
        ST_RD_RX0,
        ST_WR_SSCLR,
        ST_RESP,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_req_t;

    function automatic wb_req_t wb_wr(input logic [4:0] a, input logic [31:0] d);
        wb_req_t r;
        r.adr = a;
        r.dat = d;
        r.sel = 4'hf;
        r.we  = 1'b1;
        return r;
    endfunction

    function automatic wb_req_t wb_rd(input logic [4:0] a);
        wb_req_t r;
        r.adr = a;
        r.dat = 32'd0;
        r.sel = 4'hf;
        r.we  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/spi_xip_wb_master.sv
// Single-access Wishbone master.
//  req_i (1-cycle pulse) with req_d_i starts one access when idle. cyc/stb and
//  adr/dat/sel/we are held stable until wb_ack_i or wb_err_i, then cyc/stb
//  drop. done_o / err_o pulse for one cycle afterwards; rdata_o is valid
//  with done_o. All outputs are registered and cleared by the async reset.
module spi_xip_wb_master
    import spi_xip_pkg::*;
(
    input  logic        clock,
    input  logic        reset,      // async, active low
    input  logic        req_i,
    input  wb_req_t     req_d_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    logic        cyc_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    wb_req_t     cur_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            cur_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (!cyc_q) begin
                if (req_i) begin
                    cyc_q <= 1'b1;
                    cur_q <= req_d_i;
                end
            end else if (wb_err_i) begin
                cyc_q <= 1'b0;
                err_q <= 1'b1;
            end else if (wb_ack_i) begin
                cyc_q   <= 1'b0;
                done_q  <= 1'b1;
                rdata_q <= wb_dat_i;
            end
        end
    end

    assign done_o   = done_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_adr_o = cur_q.adr;
    assign wb_dat_o = cur_q.dat;
    assign wb_sel_o = cur_q.sel;
    assign wb_we_o  = cur_q.we;

endmodule

// File: rtl/spi_xip_apb_bridge.sv
// APB slave in front of the Wishbone SPI master (spi_top).
//  SPI window  : one pass-through WB access per APB transfer.
//  Flash window: each read runs an XIP sequence (TX1, DIVIDER, SS, CTRL,
//                CTRL+GO, poll GO_BSY, read RX0, clear SS) and returns the
//                word, optionally byte-reversed. Flash writes, unmapped
//                addresses, WB errors and poll timeout answer with PSLVERR.
// Ports: clock/reset (async active low), APB slave in_*, WB master wb_*,
//        xip_busy high while an XIP sequence is in flight.
module spi_xip_apb_bridge
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
    parameter logic [31:0] SPI_BASE   = 32'h1000_1000,
    parameter logic [31:0] SPI_END    = 32'h1000_1fff,
    parameter int          SS_NUM     = 8,
    parameter int          FLASH_SS   = 0,
    parameter logic [15:0] DIVIDER    = 16'd1,
    parameter logic [7:0]  READ_CMD   = 8'h03,
    parameter bit          BYTE_SWAP  = 1'b1,
    parameter logic [15:0] TIMEOUT    = 16'd4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        xip_busy
);

    localparam logic [31:0] SS_MASK = (SS_NUM >= 32) ? 32'hffff_ffff
                                    : ((32'd1 << SS_NUM) - 32'd1);
    localparam logic [31:0] SS_XIP  = (32'd1 << FLASH_SS) & SS_MASK;

    state_e      state_q;
    logic        req_q;
    wb_req_t     wreq_q;
    logic        pready_q;
    logic        pslverr_q;
    logic [31:0] prdata_q;
    logic        busy_q;
    logic [15:0] cnt_q;
    logic [31:0] rx_q;

    logic        m_done;
    logic        m_err;
    logic [31:0] m_rdata;

    logic is_flash;
    logic is_spi;
    assign is_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
    assign is_spi   = (in_paddr >= SPI_BASE) && (in_paddr <= SPI_END);

    logic unused_ok;
    assign unused_ok = ^in_pprot;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            wreq_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'd0;
            busy_q    <= 1'b0;
            cnt_q     <= 16'd0;
            rx_q      <= 32'd0;
        end else begin
            // pready/prdata/pslverr are single-cycle; zero unless set below
            req_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'd0;
            if (m_err) begin
                state_q   <= ST_ERR;
                pready_q  <= 1'b1;
                pslverr_q <= 1'b1;
                busy_q    <= 1'b0;
                cnt_q     <= 16'd0;
            end else begin
                case (state_q)
                    ST_IDLE: if (in_psel && in_penable) begin
                        if (is_flash && !in_pwrite) begin
                            state_q <= ST_WR_TX1;
                            busy_q  <= 1'b1;
                            req_q   <= 1'b1;
                            wreq_q  <= wb_wr(REG_TX1, {READ_CMD, in_paddr[23:0]});
                        end else if (is_spi && !is_flash) begin
                            state_q <= ST_PASS;
                            req_q   <= 1'b1;
                            wreq_q  <= '{adr: in_paddr[4:0], dat: in_pwdata,
                                         sel: in_pstrb, we: in_pwrite};
                        end else begin
                            state_q   <= ST_ERR;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                        end
                    end
                    ST_PASS: if (m_done) begin
                        state_q  <= ST_RESP;
                        pready_q <= 1'b1;
                        prdata_q <= m_rdata;
                    end
                    ST_WR_TX1: if (m_done) begin
                        state_q <= ST_WR_DIV;
                        req_q   <= 1'b1;
                        wreq_q  <= wb_wr(REG_DIV, {16'd0, DIVIDER});
                    end
                    ST_WR_DIV: if (m_done) begin
                        state_q <= ST_WR_SS;
                        req_q   <= 1'b1;
                        wreq_q  <= wb_wr(REG_SS, SS_XIP);
                    end
                    ST_WR_SS: if (m_done) begin
                        state_q <= ST_WR_CTRL;
                        req_q   <= 1'b1;
                        wreq_q  <= wb_wr(REG_CTRL, CTRL_XIP);
                    end
                    ST_WR_CTRL: if (m_done) begin
                        state_q <= ST_WR_GO;
                        req_q   <= 1'b1;
                        wreq_q  <= wb_wr(REG_CTRL, CTRL_XIP_GO);
                    end
                    ST_WR_GO: if (m_done) begin
                        state_q <= ST_POLL;
                        req_q   <= 1'b1;
                        wreq_q  <= wb_rd(REG_CTRL);
                    end
                    // cnt_q counts completed polls that still saw GO_BSY
                    ST_POLL: if (m_done) begin
                        if (!m_rdata[CTRL_GO_BSY]) begin
                            state_q <= ST_RD_RX0;
                            cnt_q   <= 16'd0;
                            req_q   <= 1'b1;
                            wreq_q  <= wb_rd(REG_RX0);
                        end else if (cnt_q >= TIMEOUT - 16'd1) begin
                            state_q   <= ST_ERR;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            busy_q    <= 1'b0;
                            cnt_q     <= 16'd0;
                        end else begin
                            cnt_q  <= cnt_q + 16'd1;
                            req_q  <= 1'b1;
                            wreq_q <= wb_rd(REG_CTRL);
                        end
                    end
                    ST_RD_RX0: if (m_done) begin
                        rx_q    <= BYTE_SWAP ? bswap32(m_rdata) : m_rdata;
                        state_q <= ST_WR_SSCLR;
                        req_q   <= 1'b1;
                        wreq_q  <= wb_wr(REG_SS, 32'd0);
                    end
                    ST_WR_SSCLR: if (m_done) begin
                        state_q  <= ST_RESP;
                        pready_q <= 1'b1;
                        prdata_q <= rx_q;
                        busy_q   <= 1'b0;
                    end
                    ST_RESP: state_q <= ST_IDLE;
                    ST_ERR:  state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    spi_xip_wb_master u_wbm (
        .clock    (clock),
        .reset    (reset),
        .req_i    (req_q),
        .req_d_i  (wreq_q),
        .done_o   (m_done),
        .err_o    (m_err),
        .rdata_o  (m_rdata),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_stb_o (wb_stb_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    assign in_pready  = pready_q;
    assign in_pslverr = pslverr_q;
    assign in_prdata  = prdata_q;
    assign xip_busy   = busy_q;

endmodule

// File: tb/tb_spi_xip_apb_bridge.sv
module tb_spi_xip_apb_bridge;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = 32'd0;
    logic [3:0]  pstrb = 4'd0;
    logic [2:0]  pprot = 3'd0;
    logic        in_pready, in_pslverr;
    logic [31:0] in_prdata;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i = 1'b0;
    logic        xip_busy;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    spi_xip_apb_bridge #(.TIMEOUT(16'd16)) dut (
        .clock(clock), .reset(rst_n),
        .in_paddr(paddr), .in_psel(psel), .in_penable(penable), .in_pprot(pprot),
        .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
        .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .xip_busy(xip_busy)
    );

    // ---------------- spi_top register model ----------------
    logic [31:0] regs [0:7];
    logic [31:0] flash_word = 32'h1122_3344;
    bit          never_clear = 1'b0;
    int          busy_left;
    int          acc_cnt = 0, poll_cnt = 0;
    logic [31:0] tx1_log = 0, ss_log = 0, ctrl_log = 0, div_log = 0;
    logic [4:0]  last_adr = 0;
    logic [3:0]  last_sel = 0;
    bit          cyc_seen = 1'b0;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_i  <= 1'b0;
            wb_dat_i  <= 32'd0;
            busy_left <= 0;
            for (int i = 0; i < 8; i++) regs[i] <= 32'd0;
        end else begin
            wb_ack_i <= 1'b0;
            if (wb_cyc_o) cyc_seen <= 1'b1;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
                wb_ack_i <= 1'b1;
                acc_cnt  <= acc_cnt + 1;
                last_adr <= wb_adr_o;
                last_sel <= wb_sel_o;
                if (wb_we_o) begin
                    regs[wb_adr_o[4:2]] <= wb_dat_o;
                    if (wb_adr_o == 5'h04) tx1_log <= wb_dat_o;
                    if (wb_adr_o == 5'h14) div_log <= wb_dat_o;
                    if (wb_adr_o == 5'h18 && wb_dat_o != 0) ss_log <= wb_dat_o;
                    if (wb_adr_o == 5'h10) begin
                        ctrl_log <= wb_dat_o;
                        if (wb_dat_o[8]) busy_left <= 2;
                    end
                end else if (wb_adr_o == 5'h00) begin
                    wb_dat_i <= flash_word;
                end else if (wb_adr_o == 5'h10) begin
                    poll_cnt <= poll_cnt + 1;
                    wb_dat_i <= {regs[4][31:9], (never_clear || busy_left != 0), regs[4][7:0]};
                    if (busy_left != 0) busy_left <= busy_left - 1;
                end else begin
                    wb_dat_i <= regs[wb_adr_o[4:2]];
                end
            end
        end
    end

    // ---------------- APB transfer ----------------
    logic [31:0] rd;
    logic        er, ok, leak, bsy;

    task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] st);
        bit done;
        ok = 0; leak = 0; bsy = 0; rd = 0; er = 0; done = 0;
        @(posedge clock); #1;
        paddr = a; pwrite = w; pwdata = wd; pstrb = st; psel = 1; penable = 0;
        @(posedge clock); #1;
        penable = 1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clock);
            if (xip_busy) bsy = 1;
            if (in_pready) begin
                rd = in_prdata; er = in_pslverr; ok = 1; done = 1;
            end else if (in_prdata !== 32'd0 || in_pslverr !== 1'b0) leak = 1;
        end
        @(posedge clock); #1;
        psel = 0; penable = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if ({in_pready, in_pslverr, xip_busy} !== 3'b000) begin failures++;
            $display("FAIL reset_flags got=%b exp=000", {in_pready, in_pslverr, xip_busy}); end
        checks++; if (in_prdata !== 32'd0) begin failures++;
            $display("FAIL reset_prdata got=%h exp=0", in_prdata); end
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== 43'd0) begin failures++;
            $display("FAIL reset_wb got cyc=%b stb=%b adr=%h dat=%h exp all 0", wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o); end
        @(posedge clock); #1; rst_n = 1;
    endtask

    task automatic test_flash_read;
        int a0;
        flash_word = 32'h1122_3344; never_clear = 0; a0 = acc_cnt;
        apb(32'h3000_0010, 0, 0, 4'h0);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL flash_timeout got=%b exp=1", ok); end
        checks++; if (rd !== 32'h4433_2211) begin failures++;
            $display("FAIL flash_rdata got=%h exp=44332211", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL flash_slverr got=%b exp=0", er); end
        checks++; if (tx1_log !== 32'h0300_0010) begin failures++;
            $display("FAIL flash_tx1 got=%h exp=03000010", tx1_log); end
        checks++; if (ss_log !== 32'h1) begin failures++; $display("FAIL flash_ss got=%h exp=1", ss_log); end
        checks++; if (ctrl_log !== 32'h2540) begin failures++; $display("FAIL flash_ctrl got=%h exp=2540", ctrl_log); end
        checks++; if (div_log !== 32'h1) begin failures++; $display("FAIL flash_div got=%h exp=1", div_log); end
        checks++; if (regs[6] !== 32'h0) begin failures++; $display("FAIL flash_ssclr got=%h exp=0", regs[6]); end
        // TX1, DIV, SS, CTRL, GO, 3 polls, RX0, SSCLR
        checks++; if (acc_cnt - a0 !== 10) begin failures++;
            $display("FAIL flash_acc got=%0d exp=10", acc_cnt - a0); end
        checks++; if ({bsy, xip_busy, leak} !== 3'b100) begin failures++;
            $display("FAIL flash_busy got seen/now/leak=%b exp=100", {bsy, xip_busy, leak}); end
    endtask

    task automatic test_spi_pass;
        int a0;
        a0 = acc_cnt;
        apb(32'h1000_1014, 1, 32'h5, 4'hf);
        checks++; if ({ok, er} !== 2'b10 || acc_cnt - a0 !== 1) begin failures++;
            $display("FAIL spi_wr got ok=%b err=%b acc=%0d exp ok=1 err=0 acc=1", ok, er, acc_cnt - a0); end
        a0 = acc_cnt;
        apb(32'h1000_1014, 0, 32'h0, 4'hf);
        checks++; if (rd !== 32'h5 || er !== 1'b0) begin failures++;
            $display("FAIL spi_rd got=%h err=%b exp=5 err=0", rd, er); end
        checks++; if (acc_cnt - a0 !== 1) begin failures++;
            $display("FAIL spi_rd_acc got=%0d exp=1", acc_cnt - a0); end
        apb(32'h1000_1018, 1, 32'h80, 4'h3);
        checks++; if ({last_adr, last_sel} !== {5'h18, 4'h3} || regs[6] !== 32'h80) begin failures++;
            $display("FAIL spi_sel got adr=%h sel=%h ss=%h exp adr=18 sel=3 ss=80", last_adr, last_sel, regs[6]); end
    endtask

    task automatic test_flash_write;
        cyc_seen = 0;
        apb(32'h3000_0000, 1, 32'hdead_beef, 4'hf);
        checks++; if ({ok, er} !== 2'b11) begin failures++;
            $display("FAIL fwr_err got ok=%b err=%b exp 11", ok, er); end
        checks++; if (cyc_seen !== 1'b0) begin failures++;
            $display("FAIL fwr_cyc got=%b exp=0", cyc_seen); end
    endtask

    task automatic test_unmapped;
        cyc_seen = 0;
        apb(32'h2000_0000, 0, 0, 4'h0);
        checks++; if ({ok, er} !== 2'b11 || rd !== 32'd0) begin failures++;
            $display("FAIL unmapped got ok=%b err=%b rd=%h exp 1 1 0", ok, er, rd); end
        checks++; if (cyc_seen !== 1'b0) begin failures++;
            $display("FAIL unmapped_cyc got=%b exp=0", cyc_seen); end
    endtask

    task automatic test_timeout;
        int p0;
        never_clear = 1; p0 = poll_cnt;
        apb(32'h3000_0100, 0, 0, 4'h0);
        checks++; if ({ok, er} !== 2'b11 || rd !== 32'd0) begin failures++;
            $display("FAIL tmo_err got ok=%b err=%b rd=%h exp 1 1 0", ok, er, rd); end
        checks++; if (poll_cnt - p0 !== 16) begin failures++;
            $display("FAIL tmo_polls got=%0d exp=16", poll_cnt - p0); end
        checks++; if (xip_busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%b exp=0", xip_busy); end
        never_clear = 0; flash_word = 32'hcafe_f00d;
        apb(32'h3000_0200, 0, 0, 4'h0);
        checks++; if (rd !== 32'h0df0_feca || er !== 1'b0) begin failures++;
            $display("FAIL tmo_next got=%h err=%b exp=0df0feca 0", rd, er); end
    endtask

    task automatic test_reset_mid;
        int p0;
        bit hit;
        never_clear = 1; p0 = poll_cnt; hit = 0;
        @(posedge clock); #1;
        paddr = 32'h3000_0300; pwrite = 0; psel = 1; penable = 0;
        @(posedge clock); #1; penable = 1;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(posedge clock); #1;
            if (poll_cnt - p0 >= 2 && wb_cyc_o) hit = 1;
        end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rstmid_poll got=%b exp=1", hit); end
        #2; rst_n = 0; #1;
        checks++; if ({wb_cyc_o, wb_stb_o, xip_busy, in_pready, in_pslverr} !== 5'b0) begin failures++;
            $display("FAIL rstmid_out got=%b exp=00000", {wb_cyc_o, wb_stb_o, xip_busy, in_pready, in_pslverr}); end
        psel = 0; penable = 0; never_clear = 0;
        @(posedge clock); #1; rst_n = 1;
        flash_word = 32'ha1b2_c3d4;
        apb(32'h3000_0400, 0, 0, 4'h0);
        checks++; if (rd !== 32'hd4c3_b2a1 || er !== 1'b0 || ok !== 1'b1) begin failures++;
            $display("FAIL rstmid_next got=%h err=%b ok=%b exp=d4c3b2a1 0 1", rd, er, ok); end
        checks++; if (tx1_log !== 32'h0300_0400) begin failures++;
            $display("FAIL rstmid_tx1 got=%h exp=03000400", tx1_log); end
    endtask

    initial begin
        test_reset;
        test_flash_read;
        test_spi_pass;
        test_flash_write;
        test_unmapped;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
